// File: rtl/wb_write_queue.sv
// wb_write_queue: write-side front end of the 32x32 register file.
//
// Collects write-back requests from two producers (A = ALU, B = load/mul),
// buffers them in order in a DEPTH-entry FIFO and drains one write per cycle
// onto the register file port (writeReg/wa/wd, all registered). A pending-write
// lookup (hit1/hit2) lets decode detect RAW hazards against uncommitted writes.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   a_valid/a_ready     port A handshake, a_addr/a_data payload
//   b_valid/b_ready     port B handshake, b_addr/b_data payload
//   writeReg/wa/wd      register file write strobe/address/data (registered)
//   q1/q2, hit1/hit2    combinational pending-write lookup
//   count               FIFO occupancy, excluding the output stage (registered)
//
// Optional feature (macro WBQ_FWD_EN): adds fwd1/fwd2, the data of the youngest
// pending write matching q1/q2 (0 when there is no hit).
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [AW-1:0]                a_addr,
  input  logic [DW-1:0]                a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [AW-1:0]                b_addr,
  input  logic [DW-1:0]                b_data,
  output logic                         writeReg,
  output logic [AW-1:0]                wa,
  output logic [DW-1:0]                wd,
  input  logic [AW-1:0]                q1,
  input  logic [AW-1:0]                q2,
  output logic                         hit1,
  output logic                         hit2,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef WBQ_FWD_EN
  ,
  output logic [DW-1:0]                fwd1,
  output logic [DW-1:0]                fwd2
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  // FIFO storage and control
  wr_req_t          mem_q [DEPTH];
  wr_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Output stage
  logic             wr_q, wr_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [DW-1:0]    wd_q, wd_d;

  // Per-edge transfer decode
  logic             a_push, b_push, pop;
  wr_req_t          a_req, b_req;
  logic             e0_v, e1_v;
  wr_req_t          e0, e1;
  logic [PW-1:0]    wr_ptr_1, wr_ptr_2;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  // Ready depends only on the registered occupancy so count can never overflow.
  assign a_ready = (count_q <= CW'(DEPTH - 1));
  assign b_ready = (count_q <= CW'(DEPTH - 2));

  // Address 0 completes the handshake but is never queued.
  assign a_push = a_valid && a_ready && (a_addr != '0);
  assign b_push = b_valid && b_ready && (b_addr != '0);
  assign a_req  = '{addr: a_addr, data: a_data};
  assign b_req  = '{addr: b_addr, data: b_data};
  assign pop    = (count_q != '0);

  assign wr_ptr_1 = ptr_inc(wr_ptr_q);
  assign wr_ptr_2 = ptr_inc(wr_ptr_1);

  assign writeReg = wr_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign count    = count_q;

  // Next state: drain head (or bypass oldest new request), enqueue the rest in A-then-B order.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    e0_v     = 1'b0;
    e1_v     = 1'b0;
    e0       = a_req;
    e1       = b_req;

    if (pop) begin
      wr_d             = 1'b1;
      wa_d             = mem_q[rd_ptr_q].addr;
      wd_d             = mem_q[rd_ptr_q].data;
      vld_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d         = ptr_inc(rd_ptr_q);
      if (a_push) begin
        e0_v = 1'b1;
        e0   = a_req;
        e1_v = b_push;
        e1   = b_req;
      end else if (b_push) begin
        e0_v = 1'b1;
        e0   = b_req;
      end
    end else if (a_push) begin
      wr_d = 1'b1;
      wa_d = a_addr;
      wd_d = a_data;
      e0_v = b_push;
      e0   = b_req;
    end else if (b_push) begin
      wr_d = 1'b1;
      wa_d = b_addr;
      wd_d = b_data;
    end

    if (e0_v) begin
      mem_d[wr_ptr_q] = e0;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_1;
    end
    if (e1_v) begin
      mem_d[wr_ptr_1] = e1;
      vld_d[wr_ptr_1] = 1'b1;
      wr_ptr_d        = wr_ptr_2;
    end

    count_d = count_q - CW'(pop) + CW'(e0_v) + CW'(e1_v);
  end

  // State registers; reset discards all pending writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wr_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  // Hazard lookup against queued entries and the output stage.
  always_comb begin
    hit1 = wr_q && (wa_q == q1);
    hit2 = wr_q && (wa_q == q2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i].addr == q1)) hit1 = 1'b1;
      if (vld_q[i] && (mem_q[i].addr == q2)) hit2 = 1'b1;
    end
    hit1 = hit1 && (q1 != '0);
    hit2 = hit2 && (q2 != '0);
  end

`ifdef WBQ_FWD_EN
  // Youngest match wins: start from the output stage, then walk head to tail overwriting.
  always_comb begin
    int unsigned idx;
    fwd1 = '0;
    fwd2 = '0;
    idx  = 0;
    if (wr_q && (wa_q == q1)) fwd1 = wd_q;
    if (wr_q && (wa_q == q2)) fwd2 = wd_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = 32'(rd_ptr_q) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (vld_q[PW'(idx)] && (mem_q[PW'(idx)].addr == q1)) fwd1 = mem_q[PW'(idx)].data;
      if (vld_q[PW'(idx)] && (mem_q[PW'(idx)].addr == q2)) fwd2 = mem_q[PW'(idx)].data;
    end
    if (q1 == '0) fwd1 = '0;
    if (q2 == '0) fwd2 = '0;
  end
`endif

endmodule
